// File: rtl/key_debounce_pulse.sv
// Per-key synchroniser, debouncer and press/release pulse generator.
// Ports: clk, rst (sync, active-high), key[w_key] raw in;
//   key_level debounced level, key_press/key_release 1-cycle pulses,
//   any_press = OR of key_press. Optional auto-repeat: KEY_DEBOUNCE_REPEAT_EN.
module key_debounce_pulse #(
  parameter int w_key      = 4,
  parameter int ACTIVE_LOW = 0,
  parameter int DB_CYCLES  = 500000,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [w_key-1:0] key,
  output logic [w_key-1:0] key_level,
  output logic [w_key-1:0] key_press,
  output logic [w_key-1:0] key_release,
  output logic             any_press
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [w_key-1:0] REL =
    (ACTIVE_LOW != 0) ? '1 : '0;

  logic [w_key-1:0] sync1;
  logic [w_key-1:0] sync2;
  logic [w_key-1:0] s;

  // Sync flops idle at the released raw value so reset
  // never looks like a key event.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= REL;
      sync2 <= REL;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ REL;

  for (genvar i = 0; i < w_key; i++) begin : g_key
    logic [CW-1:0] cnt;
    logic          lvl;
    logic          prs;
    logic          rls;
    logic          acc;
    logic          acc_prs;
    logic          acc_rls;
    logic          rep_hit;

    assign acc     = (s[i] != lvl) && (cnt == DB_LAST);
    assign acc_prs = acc && s[i];
    assign acc_rls = acc && !s[i];

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam int RMAX =
      (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [RW-1:0] D_LAST = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] P_LAST = RW'(REP_PERIOD - 1);

    logic [RW-1:0] rcnt;
    logic          rfirst;

    // Held-key repeat; a release being accepted wins.
    assign rep_hit = lvl && !acc_rls &&
      (rcnt == (rfirst ? D_LAST : P_LAST));

    always_ff @(posedge clk) begin
      if (rst || !lvl || acc_prs) begin
        rcnt   <= '0;
        rfirst <= 1'b1;
      end else if (rep_hit) begin
        rcnt   <= '0;
        rfirst <= 1'b0;
      end else if (!acc_rls) begin
        rcnt   <= rcnt + 1'b1;
      end
    end
`else
    assign rep_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
        lvl <= 1'b0;
        prs <= 1'b0;
        rls <= 1'b0;
      end else begin
        prs <= acc_prs | rep_hit;
        rls <= acc_rls;
        if (s[i] == lvl) begin
          cnt <= '0;
        end else if (acc) begin
          cnt <= '0;
          lvl <= s[i];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign key_level[i]   = lvl;
    assign key_press[i]   = prs;
    assign key_release[i] = rls;
  end

  assign any_press = |key_press;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed bench for key_debounce_pulse.
// DB_CYCLES=8 -> events visible 10 cycles after the first sample.
module tb_key_debounce_pulse;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic       any_press;

  int checks   = 0;
  int failures = 0;

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  key_debounce_pulse #(
    .w_key(4), .ACTIVE_LOW(0), .DB_CYCLES(8),
    .REP_DELAY(20), .REP_PERIOD(5)
  ) dut (
    .clk(clk), .rst(rst), .key(key),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .any_press(any_press)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_prs"}, 32'(key_press), 32'h0);
    chk({tag, "_rls"}, 32'(key_release), 32'h0);
    chk({tag, "_any"}, 32'(any_press), 32'h0);
  endtask

  initial begin
    logic ep;
    rst = 1'b1;
    key = 4'h0;
    cyc(3);
    chk("rst_lvl", 32'(key_level), 32'h0);
    idle_chk("rst");
    rst = 1'b0;
    cyc(2);

    // single press, then long hold
    key = 4'b0001;
    cyc(9);
    chk("t1_c9_prs", 32'(key_press), 32'h0);
    chk("t1_c9_lvl", 32'(key_level), 32'h0);
    cyc(1);
    chk("t1_c10_prs", 32'(key_press), 32'h1);
    chk("t1_c10_lvl", 32'(key_level), 32'h1);
    chk("t1_c10_any", 32'(any_press), 32'h1);
    chk("t1_c10_rls", 32'(key_release), 32'h0);
    for (int i = 1; i <= 49; i++) begin
      cyc(1);
      ep = REP && i >= 20 && (i % 5) == 0;
      chk("t1_hold_prs", 32'(key_press), 32'(ep));
      chk("t1_hold_lvl", 32'(key_level), 32'h1);
    end
    key = 4'b0000;
    for (int i = 50; i <= 65; i++) begin
      cyc(1);
      ep = REP && i <= 58 && (i % 5) == 0;
      chk("t1_rel_prs", 32'(key_press), 32'(ep));
      chk("t1_rel_rls", 32'(key_release),
          32'(i == 59));
      chk("t1_rel_lvl", 32'(key_level),
          32'(i < 59));
    end

    // bounce on key[1], then steady
    for (int b = 0; b < 4; b++) begin
      key = (b % 2 == 0) ? 4'b0010 : 4'b0000;
      for (int j = 0; j < 3; j++) begin
        cyc(1);
        idle_chk("t2_bounce");
        chk("t2_bounce_lvl", 32'(key_level), 32'h0);
      end
    end
    key = 4'b0010;
    cyc(9);
    chk("t2_c9_prs", 32'(key_press), 32'h0);
    cyc(1);
    chk("t2_c10_prs", 32'(key_press), 32'h2);
    chk("t2_c10_lvl", 32'(key_level), 32'h2);
    cyc(1);
    chk("t2_c11_prs", 32'(key_press), 32'h0);
    key = 4'b0000;
    cyc(9);
    chk("t2_r9_rls", 32'(key_release), 32'h0);
    cyc(1);
    chk("t2_r10_rls", 32'(key_release), 32'h2);
    chk("t2_r10_any", 32'(any_press), 32'h0);
    chk("t2_r10_lvl", 32'(key_level), 32'h0);
    cyc(2);

    // short pulse rejected
    key = 4'b0001;
    cyc(5);
    key = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      idle_chk("t3_glitch");
      chk("t3_lvl", 32'(key_level), 32'h0);
    end

    // simultaneous keys 2 and 3
    key = 4'b1100;
    cyc(9);
    chk("t4_c9_prs", 32'(key_press), 32'h0);
    cyc(1);
    chk("t4_c10_prs", 32'(key_press), 32'hC);
    chk("t4_c10_any", 32'(any_press), 32'h1);
    chk("t4_c10_lvl", 32'(key_level), 32'hC);
    cyc(1);
    key = 4'b0000;
    cyc(9);
    chk("t4_r9_rls", 32'(key_release), 32'h0);
    cyc(1);
    chk("t4_r10_rls", 32'(key_release), 32'hC);
    chk("t4_r10_prs", 32'(key_press), 32'h0);
    chk("t4_r10_lvl", 32'(key_level), 32'h0);
    cyc(1);
    chk("t4_r11_rls", 32'(key_release), 32'h0);
    cyc(2);

    // reset mid-debounce
    key = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      idle_chk("t5_pre");
    end
    rst = 1'b1;
    cyc(1);
    idle_chk("t5_rst");
    chk("t5_rst_lvl", 32'(key_level), 32'h0);
    rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      cyc(1);
      idle_chk("t5_wait");
    end
    cyc(1);
    chk("t5_c10_prs", 32'(key_press), 32'h1);
    chk("t5_c10_lvl", 32'(key_level), 32'h1);
    cyc(1);
    key = 4'b0000;
    cyc(10);
    chk("t5_rel", 32'(key_release), 32'h1);
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
